// File: rtl/systolic_skew_feeder.sv
// Drains one tile from the input buffer and feeds the array edge.
// Lane k is delayed k cycles behind lane 0 to form the diagonal wavefront.
module systolic_skew_feeder #(
  parameter int LANES = 3,
  parameter int ELEM_WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int DATA_WIDTH = LANES * ELEM_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_buf_data,
  output logic                  o_buf_rd,
  output logic [DATA_WIDTH-1:0] o_lane_data,
  output logic [LANES-1:0]      o_lane_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int RW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [RW-1:0] rd_cnt;
  logic [RW-1:0] rd_cnt_n;
  logic [DW-1:0] dr_cnt;
  logic [DW-1:0] dr_cnt_n;
  logic          cap_vld;

  always_comb begin
    state_n  = state;
    rd_cnt_n = rd_cnt;
    dr_cnt_n = dr_cnt;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_n  = READ;
          rd_cnt_n = RW'(DEPTH);
        end
      end
      READ: begin
        rd_cnt_n = rd_cnt - RW'(1);
        if (rd_cnt == RW'(1)) begin
          state_n  = DRAIN;
          dr_cnt_n = DW'(LANES);
        end
      end
      DRAIN: begin
        // LANES+1 drain cycles flush the deepest skew lane
        if (dr_cnt == '0) begin
          state_n = IDLE;
        end else begin
          dr_cnt_n = dr_cnt - DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      dr_cnt   <= '0;
      o_buf_rd <= 1'b0;
      cap_vld  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_n;
      rd_cnt   <= rd_cnt_n;
      dr_cnt   <= dr_cnt_n;
      o_buf_rd <= (state_n == READ);
      cap_vld  <= o_buf_rd;
      o_busy   <= (state_n != IDLE);
      o_done   <= (state == DRAIN) && (state_n == IDLE);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [ELEM_WIDTH-1:0] d [k+1];
    logic [k:0]            v;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        for (int j = 0; j <= k; j++) begin
          d[j] <= '0;
        end
        v <= '0;
      end else begin
        // invalid slots carry zero so no stale element leaks out
        v[0] <= cap_vld;
        d[0] <= cap_vld ? i_buf_data[k*ELEM_WIDTH +: ELEM_WIDTH] : '0;
        for (int j = 1; j <= k; j++) begin
          d[j] <= d[j-1];
          v[j] <= v[j-1];
        end
      end
    end

    assign o_lane_data[k*ELEM_WIDTH +: ELEM_WIDTH] = d[k];
    assign o_lane_valid[k] = v[k];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a behavioural buffer model.
// Expected per-cycle outputs are queued at stimulus time and popped per cycle.
module tb_systolic_skew_feeder;

  logic        clk;
  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic [23:0] bda;
  logic        a_rd;
  logic [23:0] a_data;
  logic [2:0]  a_vld;
  logic        a_busy;
  logic        a_done;
  logic [31:0] bdb;
  logic        b_rd;
  logic [31:0] b_data;
  logic [3:0]  b_vld;
  logic        b_busy;
  logic        b_done;

  logic [23:0] mem_a [4];
  logic [31:0] mem_b [8];
  logic [1:0]  rpa;
  logic [2:0]  rpb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd;
    logic        busy;
    logic        done;
    logic [31:0] data;
    logic [3:0]  vld;
  } exp_t;

  exp_t q[$];

  systolic_skew_feeder dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
    .i_buf_data(bda), .o_buf_rd(a_rd), .o_lane_data(a_data),
    .o_lane_valid(a_vld), .o_busy(a_busy), .o_done(a_done)
  );

  systolic_skew_feeder #(.LANES(4), .ELEM_WIDTH(8), .DEPTH(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
    .i_buf_data(bdb), .o_buf_rd(b_rd), .o_lane_data(b_data),
    .o_lane_valid(b_vld), .o_busy(b_busy), .o_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      rpa <= '0;
      bda <= '0;
      rpb <= '0;
      bdb <= '0;
    end else begin
      if (a_rd) begin
        bda <= mem_a[rpa];
        rpa <= rpa + 2'd1;
      end
      if (b_rd) begin
        bdb <= mem_b[rpb];
        rpb <= rpb + 3'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int L, input int D, input logic [31:0] w [8]);
    exp_t e;
    int idx;
    for (int c = 1; c <= D + L + 2; c++) begin
      e.rd   = (c <= D);
      e.busy = (c <= D + L + 1);
      e.done = (c == D + L + 2);
      e.data = '0;
      e.vld  = '0;
      for (int k = 0; k < L; k++) begin
        idx = c - 3 - k;
        if (idx >= 0 && idx < D) begin
          e.vld[k] = 1'b1;
          e.data[k*8 +: 8] = w[idx][k*8 +: 8];
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic push_idle();
    exp_t e;
    e.rd = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    e.data = '0; e.vld = '0;
    q.push_back(e);
  endtask

  task automatic chk_a(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk1({tag, "_rd"}, 32'(a_rd), 32'(e.rd));
      chk1({tag, "_busy"}, 32'(a_busy), 32'(e.busy));
      chk1({tag, "_done"}, 32'(a_done), 32'(e.done));
      chk1({tag, "_data"}, {8'h0, a_data}, e.data);
      chk1({tag, "_vld"}, {29'h0, a_vld}, {28'h0, e.vld});
    end
  endtask

  task automatic chk_b(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk1({tag, "_rd"}, 32'(b_rd), 32'(e.rd));
      chk1({tag, "_busy"}, 32'(b_busy), 32'(e.busy));
      chk1({tag, "_done"}, 32'(b_done), 32'(e.done));
      chk1({tag, "_data"}, b_data, e.data);
      chk1({tag, "_vld"}, {28'h0, b_vld}, {28'h0, e.vld});
    end
  endtask

  task automatic load_a(input logic [23:0] base, output logic [31:0] w [8]);
    for (int i = 0; i < 8; i++) w[i] = '0;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = base + 24'(i) * 24'h030303;
      w[i] = {8'h0, mem_a[i]};
    end
  endtask

  initial begin
    logic [31:0] w [8];
    rst_n = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    for (int i = 0; i < 8; i++) mem_b[i] = '0;
    for (int i = 0; i < 4; i++) mem_a[i] = '0;

    for (int c = 0; c < 3; c++) begin
      tick();
      push_idle();
      chk_a("rst_a");
      push_idle();
      chk_b("rst_b");
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n = 1'b1;
    tick();

    load_a(24'h030201, w);
    chk1("preload_w2", w[2], 32'h090807);
    push_exp(3, 4, w);
    push_idle();
    start_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_a = (c == 4);
      if (c == 3) chk1("c3_data", {8'h0, a_data}, 32'h000001);
      if (c == 5) chk1("c5_data", {8'h0, a_data}, 32'h030507);
      if (c == 5) chk1("c5_vld", {29'h0, a_vld}, 32'h7);
      chk_a("tile1");
    end
    start_a = 1'b0;

    load_a(24'h100F0E, w);
    push_exp(3, 4, w);
    start_a = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start_a = 1'b0;
      if (c == 6) begin
        load_a(24'h302010, w);
        push_exp(3, 4, w);
      end
      chk_a("tile2");
      if (c == 9) start_a = 1'b1;
    end
    for (int c = 10; c <= 18; c++) begin
      tick();
      start_a = 1'b0;
      chk_a("tile3");
    end

    load_a(24'h515253, w);
    push_exp(3, 4, w);
    start_a = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start_a = 1'b0;
      chk_a("pre_rst");
    end
    rst_n = 1'b0;
    q.delete();
    tick();
    push_idle();
    chk_a("mid_rst");
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      push_idle();
      chk_a("post_rst");
    end

    load_a(24'hA1B2C3, w);
    push_exp(3, 4, w);
    start_a = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start_a = 1'b0;
      chk_a("tile4");
    end

    for (int i = 0; i < 8; i++) begin
      mem_b[i] = 32'h04030201 + 32'(i) * 32'h04040404;
      w[i] = mem_b[i];
    end
    push_exp(4, 8, w);
    start_b = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start_b = 1'b0;
      if (c == 6) chk1("b_l3_first", 32'(b_vld[3]), 32'h1);
      if (c == 13) chk1("b_l3_last", 32'(b_vld[3]), 32'h1);
      chk_b("sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
